// File: rtl/mips_pkg.sv
// mips_pkg: shared types and default widths for the MIPS register file.
package mips_pkg;
   typedef enum logic {INIT, READY} state_t;
   localparam int ADDR_SIZE_DEF = 5;
   localparam int WORD_SIZE_DEF = 32;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write busy bits; claims set, writes clear, claim beats write.
import mips_pkg::*;
module regfile_scoreboard #(
   parameter int ADDR_SIZE = ADDR_SIZE_DEF,
   parameter int NUM_WR    = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_set_en,
   input  logic [ADDR_SIZE-1:0]        i_set_addr,
   input  logic [NUM_WR-1:0]           i_clr_en,
   input  logic [NUM_WR*ADDR_SIZE-1:0] i_clr_addr,
   output logic [2**ADDR_SIZE-1:0]     o_busy
);
   logic [2**ADDR_SIZE-1:0] r_busy;
   logic [2**ADDR_SIZE-1:0] w_busy_nxt;
   always_comb begin
      w_busy_nxt = r_busy;
      for (int w = 0; w < NUM_WR; w++)
         if (i_clr_en[w]) w_busy_nxt[i_clr_addr[w*ADDR_SIZE +: ADDR_SIZE]] = 1'b0;
      if (i_set_en) w_busy_nxt[i_set_addr] = 1'b1;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_busy <= '0;
      else        r_busy <= w_busy_nxt;
   assign o_busy = r_busy;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with post-reset clear sequence,
// write-to-read bypass, hardwired r0 and a pending-write scoreboard.
import mips_pkg::*;
module regfile_mp #(
   parameter int ADDR_SIZE = ADDR_SIZE_DEF,
   parameter int WORD_SIZE = WORD_SIZE_DEF,
   parameter int NUM_RD    = 2,
   parameter int NUM_WR    = 1,
   parameter bit BYPASS    = 1'b1,
   parameter bit ZERO_REG  = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_RD*ADDR_SIZE-1:0] rd_addr,
   output logic [NUM_RD*WORD_SIZE-1:0] rd_data,
   output logic [NUM_RD-1:0]           rd_busy,
   input  logic [NUM_WR-1:0]           wr_en,
   input  logic [NUM_WR*ADDR_SIZE-1:0] wr_addr,
   input  logic [NUM_WR*WORD_SIZE-1:0] wr_data,
   input  logic                        claim_en,
   input  logic [ADDR_SIZE-1:0]        claim_addr,
   output logic                        init_done
);
   localparam int DEPTH = 2**ADDR_SIZE;

   state_t                 r_state, w_state_nxt;
   logic [ADDR_SIZE-1:0]   r_cnt;
   logic [WORD_SIZE-1:0]   r_mem [DEPTH];
   logic                   w_ready;
   logic [NUM_WR-1:0]      w_wen;
   logic                   w_claim;
   logic [DEPTH-1:0]       w_busy;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= INIT;
      else        r_state <= w_state_nxt;

   always_comb w_state_nxt = (r_state == INIT && r_cnt == '1) ? READY : r_state;

   always_comb init_done = (r_state == READY);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)              r_cnt <= '0;
      else if (r_state == INIT) r_cnt <= r_cnt + 1'b1;

   assign w_ready = init_done;

   // Writes and claims to r0 are dropped here so neither storage nor scoreboard sees them.
   always_comb begin
      w_wen = '0;
      for (int w = 0; w < NUM_WR; w++)
         w_wen[w] = w_ready & wr_en[w] & ~(ZERO_REG & (wr_addr[w*ADDR_SIZE +: ADDR_SIZE] == '0));
   end

   assign w_claim = w_ready & claim_en & ~(ZERO_REG & (claim_addr == '0));

   always_ff @(posedge clk)
      if (r_state == INIT) r_mem[r_cnt] <= '0;
      else
         for (int w = 0; w < NUM_WR; w++)
            if (w_wen[w]) r_mem[wr_addr[w*ADDR_SIZE +: ADDR_SIZE]] <= wr_data[w*WORD_SIZE +: WORD_SIZE];

   regfile_scoreboard #(.ADDR_SIZE(ADDR_SIZE), .NUM_WR(NUM_WR)) u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_set_en   (w_claim),
      .i_set_addr (claim_addr),
      .i_clr_en   (w_wen),
      .i_clr_addr (wr_addr),
      .o_busy     (w_busy)
   );

   always_comb begin
      logic [ADDR_SIZE-1:0] w_a;
      logic [WORD_SIZE-1:0] w_d;
      logic                 w_hit;
      w_a     = '0;
      w_d     = '0;
      w_hit   = 1'b0;
      rd_data = '0;
      rd_busy = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         w_a   = rd_addr[p*ADDR_SIZE +: ADDR_SIZE];
         w_d   = r_mem[w_a];
         w_hit = 1'b0;
         for (int w = 0; w < NUM_WR; w++)
            if (BYPASS && w_wen[w] && wr_addr[w*ADDR_SIZE +: ADDR_SIZE] == w_a) begin
               w_d   = wr_data[w*WORD_SIZE +: WORD_SIZE];
               w_hit = 1'b1;
            end
         rd_data[p*WORD_SIZE +: WORD_SIZE] = (w_ready && !(ZERO_REG && w_a == '0)) ? w_d : '0;
         rd_busy[p] = w_ready & w_busy[w_a] & ~(w_hit & ~(w_claim & (claim_addr == w_a)));
      end
   end
endmodule
